sb_config_sequencer: RTL and testbench

- Sequences configuration writes into an array of switch_box tiles.
- Accepts (tile address, 32-bit config word) commands over a valid/ready handshake.
- Drives the shared config_data bus and a one-hot per-tile config_en strobe, then holds off for a programmable settle period before accepting the next command.
- Sits between the fabric configuration host and the config_data/config_en inputs of every switch_box; also supports broadcast writes and reports errors and progress.

---
 rtl/sb_config_sequencer.sv | 145 ++++++++++++++
 tb/tb_sb_config_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sb_config_sequencer
//  Description : Sequences (tile address, config word) commands into an array
//                of switch_box tiles. Each command drives the shared
//                config_data bus plus a one-hot (or all-ones broadcast)
//                config_en strobe for one cycle, then waits SETTLE_CYCLES
//                idle cycles before accepting the next command.
//  Options     : define SB_CFG_PARITY_EN to add even-parity checking of
//                commands (cmd_parity input, sticky err_parity output).
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_config_sequencer #(
  parameter int NUM_TILES     = 16,
  parameter int ADDR_W        = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic                 cmd_bcast,
  input  logic [31:0]          cmd_data,
`ifdef SB_CFG_PARITY_EN
  input  logic                 cmd_parity,
  output logic                 err_parity,
`endif
  output logic [31:0]          config_data,
  output logic [NUM_TILES-1:0] config_en,
  output logic                 busy,
  output logic                 err_addr,
  output logic [CNT_W-1:0]     write_count
);

  // Settle counter only needs to hold SETTLE_CYCLES-1; keep at least 1 bit so
  // the SETTLE_CYCLES=0 build still has a legal (unused) register.
  localparam int                 c_cnt_w       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic               c_has_settle  = (SETTLE_CYCLES > 0);
  // One extra bit so NUM_TILES == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]    c_num_tiles   = (ADDR_W + 1)'(NUM_TILES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [c_cnt_w-1:0]   r_settle_cnt;
  logic                 w_accept;
  logic                 w_addr_bad;
  logic                 w_par_bad;
  logic                 w_issue;
  logic [NUM_TILES-1:0] w_onehot;

  assign cmd_ready  = (r_state == ST_IDLE) && !reset;
  assign busy       = (r_state != ST_IDLE);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_addr_bad = !cmd_bcast && ({1'b0, cmd_addr} >= c_num_tiles);
  assign w_onehot   = NUM_TILES'(1) << cmd_addr;

`ifdef SB_CFG_PARITY_EN
  // Even parity over the whole command; a mismatch drops the command.
  assign w_par_bad  = ((^{cmd_data, cmd_addr, cmd_bcast}) != cmd_parity);
`else
  assign w_par_bad  = 1'b0;
`endif

  // A command is issued only if it passes the parity check first, then the
  // address range check.
  assign w_issue = w_accept && !w_par_bad && !w_addr_bad;

  // Next-state decode: IDLE -> ISSUE on a good command, ISSUE lasts one
  // cycle, SETTLE runs until the settle counter is exhausted.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_issue) w_next_state = ST_ISSUE;
      ST_ISSUE:  w_next_state = c_has_settle ? ST_SETTLE : ST_IDLE;
      ST_SETTLE: if (r_settle_cnt == '0) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Settle counter: loaded while leaving ISSUE, counts down through SETTLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle_cnt <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_settle_cnt <= c_settle_load;
    end else if ((r_state == ST_SETTLE) && (r_settle_cnt != '0)) begin
      r_settle_cnt <= r_settle_cnt - c_cnt_w'(1);
    end
  end

  // Issue datapath: the accepted word/strobe are registered on accept so they
  // appear during the single ISSUE cycle; the strobe self-clears afterwards
  // while config_data keeps the last issued word.
  always_ff @(posedge clk) begin
    if (reset) begin
      config_data <= '0;
      config_en   <= '0;
      write_count <= '0;
    end else begin
      config_en <= '0;
      if (w_issue) begin
        config_data <= cmd_data;
        config_en   <= cmd_bcast ? '1 : w_onehot;
        write_count <= write_count + CNT_W'(1);
      end
    end
  end

  // Sticky out-of-range address flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_addr <= 1'b0;
    end else if (w_accept && !w_par_bad && w_addr_bad) begin
      err_addr <= 1'b1;
    end
  end

`ifdef SB_CFG_PARITY_EN
  // Sticky parity error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_parity <= 1'b0;
    end else if (w_accept && w_par_bad) begin
      err_parity <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sb_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sb_config_sequencer
//  Description : Self-checking bench for sb_config_sequencer (12 tiles,
//                settle of 2). A schedule-based reference model predicts
//                every output each cycle; directed sequences pin literal
//                values, then randomized traffic with occasional resets.
//  Options     : SB_CFG_PARITY_EN enables the parity port and its tests.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sb_config_sequencer;
  localparam int NT = 12;
  localparam int AW = 4;
  localparam int S  = 2;
  localparam int CW = 16;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_bcast = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [31:0]   cmd_data  = '0;
  logic          cmd_ready;
  logic [31:0]   config_data;
  logic [NT-1:0] config_en;
  logic          busy;
  logic          err_addr;
  logic [CW-1:0] write_count;
`ifdef SB_CFG_PARITY_EN
  logic          cmd_parity = 1'b0;
  logic          err_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sb_config_sequencer #(
    .NUM_TILES    (NT),
    .ADDR_W       (AW),
    .SETTLE_CYCLES(S),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_bcast  (cmd_bcast),
    .cmd_data   (cmd_data),
`ifdef SB_CFG_PARITY_EN
    .cmd_parity (cmd_parity),
    .err_parity (err_parity),
`endif
    .config_data(config_data),
    .config_en  (config_en),
    .busy       (busy),
    .err_addr   (err_addr),
    .write_count(write_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The model thinks in terms of "the cycle at which the block is free again"
  // and "which strobe must appear next cycle", not in states.
  int            cyc        = 0;
  int            m_ready_at = 0;
  logic [NT-1:0] m_en       = '0;
  logic [31:0]   m_data     = '0;
  logic [CW-1:0] m_count    = '0;
  logic          m_err_addr = 1'b0;
  logic          m_err_par  = 1'b0;

  // Compare all outputs each cycle, then advance the model using the inputs
  // that the next rising edge will sample.
  always @(negedge clk) begin
    logic acc;
    logic pbad;
    check("cmd_ready",   cmd_ready,   64'(!reset && (cyc >= m_ready_at)));
    check("busy",        busy,        64'(cyc < m_ready_at));
    check("config_en",   config_en,   64'(m_en));
    check("config_data", config_data, 64'(m_data));
    check("err_addr",    err_addr,    64'(m_err_addr));
    if (m_en == '0) check("write_count", write_count, 64'(m_count));
`ifdef SB_CFG_PARITY_EN
    check("err_parity",  err_parity,  64'(m_err_par));
`endif
    if (reset) begin
      m_ready_at = cyc + 1;
      m_en       = '0;
      m_data     = '0;
      m_count    = '0;
      m_err_addr = 1'b0;
      m_err_par  = 1'b0;
    end else begin
      acc  = cmd_valid && (cyc >= m_ready_at);
      pbad = 1'b0;
`ifdef SB_CFG_PARITY_EN
      pbad = ((^{cmd_data, cmd_addr, cmd_bcast}) != cmd_parity);
`endif
      m_en = '0;
      if (acc) begin
        if (pbad) begin
          m_err_par = 1'b1;
        end else if (!cmd_bcast && (int'(cmd_addr) >= NT)) begin
          m_err_addr = 1'b1;
        end else begin
          m_en       = cmd_bcast ? '1 : (NT'(1) << cmd_addr);
          m_data     = cmd_data;
          m_count    = m_count + 1'b1;
          m_ready_at = cyc + 2 + S;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic b, input logic [31:0] d);
    cmd_valid = v;
    cmd_addr  = a;
    cmd_bcast = b;
    cmd_data  = d;
`ifdef SB_CFG_PARITY_EN
    cmd_parity = ^{d, a, b};
`endif
  endtask

  task automatic wait_ready;
    int k = 0;
    while (!cmd_ready && (k < 50)) begin
      tick(1);
      k++;
    end
    check("ready_timeout", 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset_ready", 64'(cmd_ready), 64'(1));
    check("reset_en",    64'(config_en), 64'(0));
    check("reset_count", 64'(write_count), 64'(0));

    // Single write to tile 3
    drive(1'b1, 4'd3, 1'b0, 32'hA5A5_00FF);
    tick(1);
    drive(1'b0, 4'd0, 1'b0, 32'h0);
    @(negedge clk);
    check("t1_en",    64'(config_en), 64'h008);
    check("t1_data",  64'(config_data), 64'hA5A5_00FF);
    check("t1_ready", 64'(cmd_ready), 64'(0));
    for (int i = 0; i < 2; i++) begin
      tick(1);
      @(negedge clk);
      check("t1_settle_ready", 64'(cmd_ready), 64'(0));
      check("t1_settle_en",    64'(config_en), 64'(0));
    end
    check("t1_count", 64'(write_count), 64'(1));
    tick(1);
    @(negedge clk);
    check("t1_ready_back", 64'(cmd_ready), 64'(1));
    check("t1_data_hold",  64'(config_data), 64'hA5A5_00FF);

    // Back-to-back commands with cmd_valid held high
    tick(1);
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      drive(1'b1, AW'(i), 1'b0, $urandom);
      tick(1);
      if (i == 3) cmd_valid = 1'b0;
      @(negedge clk);
      check("b2b_en", 64'(config_en), 64'(NT'(1) << i));
    end
    tick(1);
    @(negedge clk);
    check("b2b_count", 64'(write_count), 64'(5));

    // Broadcast ignores the address
    wait_ready();
    drive(1'b1, 4'd9, 1'b1, 32'hFFFF_FFFF);
    tick(1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("bc_en",   64'(config_en), 64'hFFF);
    check("bc_data", 64'(config_data), 64'hFFFF_FFFF);
    tick(1);
    @(negedge clk);
    check("bc_count", 64'(write_count), 64'(6));

    // Out-of-range address, then a normal write
    wait_ready();
    drive(1'b1, 4'd13, 1'b0, 32'h1234_5678);
    tick(1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("oor_err",   64'(err_addr), 64'(1));
    check("oor_en",    64'(config_en), 64'(0));
    check("oor_count", 64'(write_count), 64'(6));
    check("oor_ready", 64'(cmd_ready), 64'(1));
    tick(1);
    drive(1'b1, 4'd2, 1'b0, 32'h0BAD_CAFE);
    tick(1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("after_oor_en", 64'(config_en), 64'h004);
    tick(1);
    @(negedge clk);
    check("after_oor_count", 64'(write_count), 64'(7));

    // Reset during SETTLE
    wait_ready();
    drive(1'b1, 4'd5, 1'b0, 32'h5555_AAAA);
    tick(1);
    cmd_valid = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy",  64'(busy), 64'(0));
    check("rst_en",    64'(config_en), 64'(0));
    check("rst_count", 64'(write_count), 64'(0));
    check("rst_err",   64'(err_addr), 64'(0));
    check("rst_ready", 64'(cmd_ready), 64'(1));

`ifdef SB_CFG_PARITY_EN
    // Bad parity is dropped; the same command with good parity issues
    tick(1);
    wait_ready();
    drive(1'b1, 4'd4, 1'b0, 32'h0000_00F1);
    cmd_parity = ~cmd_parity;
    tick(1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("par_err",   64'(err_parity), 64'(1));
    check("par_en",    64'(config_en), 64'(0));
    check("par_count", 64'(write_count), 64'(0));
    check("par_noaddr", 64'(err_addr), 64'(0));
    tick(1);
    drive(1'b1, 4'd4, 1'b0, 32'h0000_00F1);
    tick(1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("par_ok_en", 64'(config_en), 64'h010);
`endif

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      tick(1);
      reset = ($urandom_range(0, 199) == 0);
      drive(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0), $urandom);
`ifdef SB_CFG_PARITY_EN
      if ($urandom_range(0, 15) == 0) cmd_parity = ~cmd_parity;
`endif
    end
    tick(1);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    tick(10);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
